// File: rtl/fifo_pack_pkg.sv
// Shared definitions for the FIFO write-side packer: word layout, field
// positions at the default configuration, and the DATASIZE helper.
package fifo_pack_pkg;

  localparam int unsigned IN_WIDTH_DEF = 8;
  localparam int unsigned PACK_DEF     = 4;
  localparam int unsigned CNTW_DEF     = $clog2(PACK_DEF);

  // Word = {last, lane count - 1, lanes}; lane 0 sits in the LSBs.
  function automatic int unsigned datasize(input int unsigned in_width,
                                           input int unsigned pack);
    return 1 + $clog2(pack) + pack * in_width;
  endfunction

  localparam int unsigned DATASIZE_DEF = datasize(IN_WIDTH_DEF, PACK_DEF);

  localparam int unsigned LAST_BIT = DATASIZE_DEF - 1;
  localparam int unsigned CNT_MSB  = DATASIZE_DEF - 2;
  localparam int unsigned DATA_MSB = PACK_DEF * IN_WIDTH_DEF - 1;
  localparam int unsigned CNT_LSB  = DATA_MSB + 1;

  typedef struct packed {
    logic                               last;
    logic [CNTW_DEF-1:0]                cnt;
    logic [PACK_DEF*IN_WIDTH_DEF-1:0]   lanes;
  } pack_word_t;

endpackage

// File: rtl/pack_out_stage.sv
// Single-entry staging register in front of the FIFO write port, with the
// push/load handshake and the pushed-word counter.
module pack_out_stage
  import fifo_pack_pkg::*;
#(
  parameter int DATASIZE = 35
) (
  input  logic                write_clk,
  input  logic                read_reset_n,
  input  logic                load,
  input  logic [DATASIZE-1:0] load_word,
  input  logic                write_full,
  output logic                write_enable,
  output logic [DATASIZE-1:0] write_data,
  output logic                stage_ready,
  output logic [15:0]         words_written
);

  logic out_valid;

  // write_enable is gated by write_full, so the FIFO never sees a push while full.
  assign write_enable = out_valid & ~write_full;
  assign stage_ready  = ~out_valid | ~write_full;

  always_ff @(posedge write_clk or negedge read_reset_n) begin
    if (!read_reset_n) begin
      out_valid     <= 1'b0;
      write_data    <= '0;
      words_written <= '0;
    end else begin
      if (load) begin
        write_data <= load_word;
        out_valid  <= 1'b1;
      end else if (write_enable) begin
        out_valid  <= 1'b0;
      end
      if (write_enable)
        words_written <= words_written + 16'd1;
    end
  end

endmodule

// File: rtl/fifo_write_packer.sv
// Packs PACK input lanes into one dual-clock FIFO word. Define
// PACKER_FLUSH_TIMEOUT_EN to force-flush partial words after TIMEOUT idle cycles.
module fifo_write_packer
  import fifo_pack_pkg::*;
#(
  parameter  int IN_WIDTH = 8,
  parameter  int PACK     = 4,
  parameter  int TIMEOUT  = 16,
  localparam int CNTW     = $clog2(PACK),
  localparam int DATASIZE = datasize(IN_WIDTH, PACK)
) (
  input  logic                write_clk,
  input  logic                read_reset_n,
  input  logic [IN_WIDTH-1:0] in_data,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  input  logic                write_full,
  output logic                write_enable,
  output logic [DATASIZE-1:0] write_data,
  output logic [15:0]         words_written
);

  localparam int LANEW = PACK * IN_WIDTH;

  if (PACK < 2 || (PACK & (PACK - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
    $error("fifo_write_packer: PACK must be a power of two >= 2 and TIMEOUT >= 1");
  end

  logic [CNTW-1:0]     cnt;
  logic [LANEW-1:0]    acc;
  logic [LANEW-1:0]    merged;
  logic                accept;
  logic                close;
  logic                flush;
  logic                load;
  logic                stage_ready;
  logic [DATASIZE-1:0] load_word;

  assign in_ready = stage_ready;
  assign accept   = in_valid & in_ready;
  assign close    = accept & ((cnt == CNTW'(PACK - 1)) | in_last);
  assign load     = close | flush;

  always_comb begin
    merged = acc;
    for (int unsigned l = 0; l < PACK; l++) begin
      if (cnt == CNTW'(l))
        merged[l*IN_WIDTH +: IN_WIDTH] = in_data;
    end
  end

  always_comb begin
    load_word = '0;
    if (close)
      load_word = {in_last, cnt, merged};
    else if (flush)
      load_word = {1'b0, CNTW'(cnt - 1'b1), acc};
  end

`ifdef PACKER_FLUSH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] idle_timer;

  // A flush needs the staging slot, which is free exactly when in_ready is high.
  assign flush = (cnt != '0) & ~accept & stage_ready &
                 (idle_timer == TW'(TIMEOUT - 1));

  always_ff @(posedge write_clk or negedge read_reset_n) begin
    if (!read_reset_n)
      idle_timer <= '0;
    else if (accept || flush || cnt == '0)
      idle_timer <= '0;
    else if (idle_timer != TW'(TIMEOUT - 1))
      idle_timer <= idle_timer + 1'b1;
  end
`else
  assign flush = 1'b0;
`endif

  always_ff @(posedge write_clk or negedge read_reset_n) begin
    if (!read_reset_n) begin
      cnt <= '0;
      acc <= '0;
    end else if (load) begin
      cnt <= '0;
      acc <= '0;
    end else if (accept) begin
      cnt <= cnt + 1'b1;
      acc <= merged;
    end
  end

  pack_out_stage #(
    .DATASIZE(DATASIZE)
  ) u_out_stage (
    .write_clk    (write_clk),
    .read_reset_n (read_reset_n),
    .load         (load),
    .load_word    (load_word),
    .write_full   (write_full),
    .write_enable (write_enable),
    .write_data   (write_data),
    .stage_ready  (stage_ready),
    .words_written(words_written)
  );

endmodule

// File: tb/tb_fifo_write_packer.sv
// Directed bench for fifo_write_packer at default parameters; covers the
// PACKER_FLUSH_TIMEOUT_EN build and the default build.
module tb_fifo_write_packer;
  import fifo_pack_pkg::*;

  logic        write_clk;
  logic        read_reset_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic        write_full;
  logic        write_enable;
  logic [34:0] write_data;
  logic [15:0] words_written;

  int errors = 0;
  int checks = 0;

  fifo_write_packer #(
    .IN_WIDTH(8),
    .PACK    (4),
    .TIMEOUT (16)
  ) dut (
    .write_clk    (write_clk),
    .read_reset_n (read_reset_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .write_full   (write_full),
    .write_enable (write_enable),
    .write_data   (write_data),
    .words_written(words_written)
  );

  initial write_clk = 1'b0;
  always #5 write_clk = ~write_clk;

  function automatic logic [34:0] mk(input logic last, input logic [1:0] c,
                                     input logic [31:0] lanes);
    pack_word_t w;
    w.last  = last;
    w.cnt   = c;
    w.lanes = lanes;
    return w;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge write_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  initial begin
    read_reset_n = 1'b0;
    in_data      = '0;
    in_valid     = 1'b0;
    in_last      = 1'b0;
    write_full   = 1'b0;
    #1;
    check("rst_we",   64'(write_enable),  64'd0);
    check("rst_data", 64'(write_data),    64'd0);
    check("rst_ww",   64'(words_written), 64'd0);
    tick();
    tick();
    read_reset_n = 1'b1;
    tick();
    check("rst_ready", 64'(in_ready), 64'd1);

    // Full word 11..44
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    check("w1_we",   64'(write_enable), 64'd1);
    check("w1_data", 64'(write_data),   64'(mk(1'b0, 2'd3, 32'h44332211)));
    tick();
    check("w1_ww",   64'(words_written), 64'd1);
    check("w1_we0",  64'(write_enable),  64'd0);

    // Partial word closed by in_last
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b1);
    check("w2_we",   64'(write_enable), 64'd1);
    check("w2_data", 64'(write_data),   64'(mk(1'b1, 2'd2, 32'h00CCBBAA)));
    check("w2_cnt",  64'(dut.cnt),      64'd0);
    tick();
    check("w2_ww",   64'(words_written), 64'd2);

    // Backpressure: word staged while full
    write_full = 1'b1;
    send(8'hD1, 1'b0);
    send(8'hD2, 1'b0);
    send(8'hD3, 1'b0);
    send(8'hD4, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("bp_we",    64'(write_enable), 64'd0);
      check("bp_ready", 64'(in_ready),     64'd0);
      check("bp_data",  64'(write_data),   64'(mk(1'b0, 2'd3, 32'hD4D3D2D1)));
      tick();
    end
    write_full = 1'b0;
    #1;
    check("bp_rel_we",    64'(write_enable), 64'd1);
    check("bp_rel_ready", 64'(in_ready),     64'd1);
    tick();
    check("bp_ww", 64'(words_written), 64'd3);
    check("bp_we0", 64'(write_enable), 64'd0);

    // Back-to-back 01..08
    for (int i = 1; i <= 8; i++) begin
      check("b2b_ready", 64'(in_ready), 64'd1);
      send(8'(i), 1'b0);
      check("b2b_we", 64'(write_enable), (i == 4 || i == 8) ? 64'd1 : 64'd0);
      if (i == 4)
        check("b2b_data0", 64'(write_data), 64'(mk(1'b0, 2'd3, 32'h04030201)));
      if (i == 5)
        check("b2b_ww0", 64'(words_written), 64'd4);
      if (i == 8)
        check("b2b_data1", 64'(write_data), 64'(mk(1'b0, 2'd3, 32'h08070605)));
    end
    tick();
    check("b2b_ww1", 64'(words_written), 64'd5);

    // Boundaries: last ignored without valid, last on lanes 1, 0, 3
    send(8'h55, 1'b0);
    in_last = 1'b1;
    tick();
    in_last = 1'b0;
    check("ign_last_we", 64'(write_enable), 64'd0);
    send(8'h66, 1'b1);
    check("lane1_data", 64'(write_data), 64'(mk(1'b1, 2'd1, 32'h00006655)));
    send(8'h77, 1'b1);
    check("lane0_we",   64'(write_enable),  64'd1);
    check("lane0_data", 64'(write_data),    64'(mk(1'b1, 2'd0, 32'h00000077)));
    check("lane0_ww",   64'(words_written), 64'd6);
    send(8'h81, 1'b0);
    send(8'h82, 1'b0);
    send(8'h83, 1'b0);
    send(8'h84, 1'b1);
    check("lane3_data", 64'(write_data),    64'(mk(1'b1, 2'd3, 32'h84838281)));
    check("lane3_ww",   64'(words_written), 64'd7);
    tick();
    check("lane3_ww1",  64'(words_written), 64'd8);

    // Reset mid-word discards the partial word
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    read_reset_n = 1'b0;
    #1;
    check("mid_rst_we", 64'(write_enable),  64'd0);
    check("mid_rst_ww", 64'(words_written), 64'd0);
    tick();
    tick();
    check("mid_rst_we2", 64'(write_enable), 64'd0);
    read_reset_n = 1'b1;
    send(8'h10, 1'b0);
    send(8'h20, 1'b0);
    send(8'h30, 1'b0);
    send(8'h40, 1'b0);
    check("post_rst_we",   64'(write_enable), 64'd1);
    check("post_rst_data", 64'(write_data),   64'(mk(1'b0, 2'd3, 32'h40302010)));
    tick();
    check("post_rst_ww", 64'(words_written), 64'd1);

    // Idle partial word
    send(8'h5A, 1'b0);
`ifdef PACKER_FLUSH_TIMEOUT_EN
    for (int t = 1; t <= 15; t++) begin
      tick();
      check("to_wait_we", 64'(write_enable), 64'd0);
    end
    tick();
    check("to_we",   64'(write_enable), 64'd1);
    check("to_data", 64'(write_data),   64'(mk(1'b0, 2'd0, 32'h0000005A)));
    tick();
    check("to_ww", 64'(words_written), 64'd2);
`else
    for (int t = 1; t <= 40; t++) begin
      tick();
      check("hold_we", 64'(write_enable), 64'd0);
    end
    check("hold_ww", 64'(words_written), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
